clint_timer: RTL and testbench
==============================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000: byte base address of the register window, aligned to 32 bytes.
REQ-002 SHALL have parameter PRESCALE, default 1: number of clk cycles per mtime tick; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port I_dbus_req, input, 1: data-bus access request, valid for one cycle.
REQ-006 SHALL have port I_dbus_we, input, 1: 1 = write, 0 = read; qualified by I_dbus_req.
REQ-007 SHALL have port I_dbus_addr, input, 32: byte address.
REQ-008 SHALL have port I_dbus_data, input, 32: write data.
REQ-009 SHALL have port I_dbus_mask, input, 4: byte enables; bit n covers data[8n+7:8n].
REQ-010 SHALL have port O_dbus_data, output, 32: read data, valid while O_dbus_ready=1.
REQ-011 SHALL have port O_dbus_ready, output, 1: one-cycle access acknowledge.
REQ-012 SHALL have port O_timer_int, output, 1: level timer interrupt to the core's I_int[0].

Function
REQ-013 SHALL accept an access when I_dbus_req=1 and I_dbus_addr[31:5]==BASE_ADDR[31:5]; any other address is ignored, with no ready and no state change.
REQ-014 SHALL select a register by offset addr[4:2]:
- 0 = MTIME_LO
- 1 = MTIME_HI
- 2 = MTIMECMP_LO
- 3 = MTIMECMP_HI
- 4 = CTRL (bit0 EN, bit1 IE, others read 0)
- 5 = STATUS (bit0 = mtime>=mtimecmp; read-only)
- 6..7 = reserved: read 0, writes ignored, still acknowledged.
REQ-015 SHALL assert O_dbus_ready for exactly one cycle, the cycle after each accepted access; back-to-back accesses every cycle SHALL each be acknowledged.
REQ-016 SHALL present read data registered: O_dbus_data equals register contents sampled at the request edge, and 0 whenever O_dbus_ready=0 or the access was a write.
REQ-017 SHALL apply writes byte-wise per I_dbus_mask at the request edge; mask 4'b0000 writes nothing but is still acknowledged.
REQ-018 SHALL copy mtime[63:32] into a shadow register on every MTIME_LO read; an MTIME_HI read SHALL return the shadow, giving a coherent 64-bit read.
REQ-019 SHALL keep a 16-bit prescaler that counts only while EN=1 and wraps at PRESCALE-1; mtime SHALL increment by 1 on each wrap cycle.
REQ-020 SHALL carry mtime increments across the 32-bit halves and wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-021 SHALL give a bus write to MTIME_LO or MTIME_HI priority over the increment in the same cycle: that cycle takes no increment, the unwritten half holds its value, and the prescaler clears to 0.
REQ-022 SHALL hold the prescaler and mtime when EN=0 (prescaler value is retained, not cleared).
REQ-023 SHALL use an unsigned 64-bit compare for mtime>=mtimecmp, evaluated on current register values.
REQ-024 SHALL register O_timer_int each cycle as IE & (mtime>=mtimecmp), giving one cycle of latency from register state.
REQ-025 SHALL deassert O_timer_int on the cycle after mtimecmp is written above mtime or IE is cleared.

Reset
REQ-026 SHALL, while rst=0, immediately set mtime=0, shadow=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, O_dbus_ready=0, O_dbus_data=0 and O_timer_int=0.
REQ-027 SHALL drop any access in flight at reset assertion, with no ready issued.
REQ-028 SHALL ignore requests during reset; the first access is accepted on the first rising edge with rst=1.

Verification
REQ-029 Reset, then read CTRL, MTIMECMP_LO and MTIMECMP_HI -> ready 1 cycle after each request; data 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF; O_timer_int=0.
REQ-030 PRESCALE=4: write CTRL=3, run 40 cycles, read MTIME_LO -> 10 (±1 for access timing); prescaler wraps every 4th cycle.
REQ-031 Write MTIME_LO=FFFF_FFFE, MTIME_HI=0, EN=1, PRESCALE=1, wait 3 cycles, read LO then HI -> HI=1; LO and shadowed HI form a coherent pair.
REQ-032 Write MTIMECMP_HI=0, MTIMECMP_LO=20, IE=EN=1 -> O_timer_int rises 1 cycle after mtime reaches 20; write MTIMECMP_LO=FFFF_FFFF -> it falls on the next cycle.
REQ-033 Write MTIME_LO with mask 4'b0010 and data 32'h0000_AB00 on a tick cycle -> only byte1 becomes AB, no increment that cycle, prescaler=0.
REQ-034 Read to BASE_ADDR+0x40, then assert rst mid-read of MTIME_LO -> no ready for either; all outputs at reset values.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped 64-bit machine timer with a compare register,
// a clock prescaler and a level interrupt output. Single-cycle bus acknowledge
// with registered read data.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_dbus_req,
    input  logic        I_dbus_we,
    input  logic [31:0] I_dbus_addr,
    input  logic [31:0] I_dbus_data,
    input  logic [3:0]  I_dbus_mask,
    output logic [31:0] O_dbus_data,
    output logic        O_dbus_ready,
    output logic        O_timer_int
);

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_STATUS      = 3'd5,
        REG_RSVD6       = 3'd6,
        REG_RSVD7       = 3'd7
    } reg_sel_e;

    localparam logic [15:0] LP_WRAP = 16'(PRESCALE - 1);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_shadow;
    logic [15:0] r_prescaler;
    logic        r_en;
    logic        r_ie;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_int;

    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    reg_sel_e    w_sel;
    logic [31:0] w_rdata;
    logic        w_ge;
    logic        w_tick;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_unused;

    // Byte-lane merge of write data into an existing 32-bit value
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign w_acc    = I_dbus_req && (I_dbus_addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr     = w_acc && I_dbus_we;
    assign w_rd     = w_acc && !I_dbus_we;
    assign w_sel    = reg_sel_e'(I_dbus_addr[4:2]);
    assign w_ge     = (r_mtime >= r_mtimecmp);
    assign w_tick   = r_en && (r_prescaler == LP_WRAP);
    // An all-zero mask is a no-op write: it neither alters mtime nor clears the prescaler
    assign w_wr_lo  = w_wr && (w_sel == REG_MTIME_LO) && (|I_dbus_mask);
    assign w_wr_hi  = w_wr && (w_sel == REG_MTIME_HI) && (|I_dbus_mask);
    assign w_unused = ^I_dbus_addr[1:0];

    assign O_dbus_data  = r_rdata;
    assign O_dbus_ready = r_ready;
    assign O_timer_int  = r_int;

    // Read mux over current register contents; MTIME_HI returns the shadow copy
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_MTIME_LO:    w_rdata = r_mtime[31:0];
            REG_MTIME_HI:    w_rdata = r_shadow;
            REG_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            REG_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            REG_CTRL:        w_rdata = {30'd0, r_ie, r_en};
            REG_STATUS:      w_rdata = {31'd0, w_ge};
            default:         w_rdata = '0;
        endcase
    end

    // Prescaler and mtime: bus writes win over the tick and restart the prescaler
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime     <= '0;
            r_prescaler <= '0;
        end else if (w_wr_lo || w_wr_hi) begin
            r_prescaler <= '0;
            if (w_wr_lo) r_mtime[31:0]  <= f_merge(r_mtime[31:0], I_dbus_data, I_dbus_mask);
            if (w_wr_hi) r_mtime[63:32] <= f_merge(r_mtime[63:32], I_dbus_data, I_dbus_mask);
        end else if (r_en) begin
            if (w_tick) begin
                r_prescaler <= '0;
                r_mtime     <= r_mtime + 64'd1;
            end else begin
                r_prescaler <= r_prescaler + 16'd1;
            end
        end
    end

    // Compare, control and shadow registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtimecmp <= '1;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_shadow   <= '0;
        end else begin
            if (w_wr && (w_sel == REG_MTIMECMP_LO))
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], I_dbus_data, I_dbus_mask);
            if (w_wr && (w_sel == REG_MTIMECMP_HI))
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], I_dbus_data, I_dbus_mask);
            if (w_wr && (w_sel == REG_CTRL) && I_dbus_mask[0])
                {r_ie, r_en} <= I_dbus_data[1:0];
            if (w_rd && (w_sel == REG_MTIME_LO))
                r_shadow <= r_mtime[63:32];
        end
    end

    // Bus response: one-cycle ready, read data zero for writes and idle cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_rd ? w_rdata : '0;
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_int <= 1'b0;
        else      r_int <= r_ie & w_ge;
    end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: randomized and directed stimulus against a behavioural
// timer model; expected bus responses are queued and checked by a monitor.
module tb_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          PS   = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  mask  = '0;
    logic [31:0] o_data;
    logic        o_ready;
    logic        o_int;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clint_timer #(.BASE_ADDR(BASE), .PRESCALE(PS)) dut (
        .clk         (clk),
        .rst         (rst),
        .I_dbus_req  (req),
        .I_dbus_we   (we),
        .I_dbus_addr (addr),
        .I_dbus_data (wdata),
        .I_dbus_mask (mask),
        .O_dbus_data (o_data),
        .O_dbus_ready(o_ready),
        .O_timer_int (o_int)
    );

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime  = '0;
    logic [63:0] m_cmp    = '1;
    logic [31:0] m_shadow = '0;
    int          m_pc     = 0;
    logic        m_en     = 1'b0;
    logic        m_ie     = 1'b0;
    logic        exp_int  = 1'b0;
    logic [31:0] exp_q[$];

    logic        t_en_old;
    logic        t_written;
    logic [31:0] t_rd;
    int          t_off;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mtime = '0; m_cmp = '1; m_shadow = '0; m_pc = 0;
            m_en = 1'b0; m_ie = 1'b0; exp_int = 1'b0;
            exp_q.delete();
        end else begin
            exp_int   = m_ie && (m_mtime >= m_cmp);
            t_en_old  = m_en;
            t_written = 1'b0;
            if (req && (addr[31:5] == BASE[31:5])) begin
                t_off = int'(addr[4:2]);
                if (!we) begin
                    case (t_off)
                        0: t_rd = m_mtime[31:0];
                        1: t_rd = m_shadow;
                        2: t_rd = m_cmp[31:0];
                        3: t_rd = m_cmp[63:32];
                        4: t_rd = {30'd0, m_ie, m_en};
                        5: t_rd = {31'd0, (m_mtime >= m_cmp)};
                        default: t_rd = 32'd0;
                    endcase
                    exp_q.push_back(t_rd);
                    if (t_off == 0) m_shadow = m_mtime[63:32];
                end else begin
                    exp_q.push_back(32'd0);
                    case (t_off)
                        0: if (mask != 4'd0) begin
                               m_mtime[31:0] = merge(m_mtime[31:0], wdata, mask);
                               t_written = 1'b1;
                           end
                        1: if (mask != 4'd0) begin
                               m_mtime[63:32] = merge(m_mtime[63:32], wdata, mask);
                               t_written = 1'b1;
                           end
                        2: m_cmp[31:0]  = merge(m_cmp[31:0], wdata, mask);
                        3: m_cmp[63:32] = merge(m_cmp[63:32], wdata, mask);
                        4: if (mask[0]) begin m_en = wdata[0]; m_ie = wdata[1]; end
                        default: ;
                    endcase
                end
            end
            if (t_written) m_pc = 0;
            else if (t_en_old) begin
                if (m_pc == PS - 1) begin
                    m_pc = 0;
                    m_mtime = m_mtime + 64'd1;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    logic [31:0] mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ready", {63'd0, o_ready}, 64'd1);
            check("rdata", {32'd0, o_data}, {32'd0, mon_e});
        end else begin
            check("ready_idle", {63'd0, o_ready}, 64'd0);
            check("rdata_idle", {32'd0, o_data}, 64'd0);
        end
        check("timer_int", {63'd0, o_int}, {63'd0, exp_int});
    end

    // ---------------- stimulus ----------------
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; mask = m;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0; we = 1'b0;
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        // requests during reset are ignored
        acc(1'b1, BASE + 32'h10, 32'h3, 4'hF);
        acc(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        idle(1);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_int", {63'd0, o_int}, 64'd0);
        // first edge with reset released accepts the access
        @(negedge clk);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = BASE + 32'h10; mask = 4'hF;
        acc(1'b0, BASE + 32'h08, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h0C, 32'h0, 4'hF);
        idle(2);

        // prescaled counting
        acc(1'b1, BASE + 32'h10, 32'h3, 4'hF);
        idle(40);
        acc(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        idle(2);

        // carry across the 32-bit halves and coherent 64-bit read
        acc(1'b1, BASE + 32'h00, 32'hFFFF_FFFE, 4'hF);
        acc(1'b1, BASE + 32'h04, 32'h0, 4'hF);
        idle(12);
        acc(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h04, 32'h0, 4'hF);
        idle(2);

        // full 64-bit wrap
        acc(1'b1, BASE + 32'h00, 32'hFFFF_FFF0, 4'hF);
        acc(1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
        idle(80);
        acc(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h04, 32'h0, 4'hF);
        idle(2);

        // interrupt rise and fall
        acc(1'b1, BASE + 32'h00, 32'h0, 4'hF);
        acc(1'b1, BASE + 32'h04, 32'h0, 4'hF);
        acc(1'b1, BASE + 32'h0C, 32'h0, 4'hF);
        acc(1'b1, BASE + 32'h08, 32'd20, 4'hF);
        idle(100);
        acc(1'b0, BASE + 32'h14, 32'h0, 4'hF);
        acc(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
        idle(3);

        // partial-byte mtime writes spanning a tick, then read back
        for (int i = 0; i < PS; i++) acc(1'b1, BASE + 32'h00, 32'h0000_AB00, 4'b0010);
        acc(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        acc(1'b1, BASE + 32'h00, 32'h1234_5678, 4'b0000);
        acc(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        idle(2);

        // reserved slots, status, out-of-window
        acc(1'b1, BASE + 32'h18, 32'hDEAD_BEEF, 4'hF);
        acc(1'b0, BASE + 32'h18, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h1C, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h14, 32'h0, 4'hF);
        acc(1'b1, BASE + 32'h40, 32'h0, 4'hF);
        acc(1'b1, BASE - 32'h4, 32'h0, 4'hF);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                logic [31:0] a;
                logic [31:0] d;
                a = BASE + 32'($urandom_range(0, 7)) * 32'd4;
                if ($urandom_range(0, 9) == 0) a = a + 32'h20 * 32'($urandom_range(1, 100));
                d = $urandom();
                if ($urandom_range(0, 1) == 1) d = d & 32'h0000_01FF;
                acc(($urandom_range(0, 1) == 1), a, d, 4'($urandom_range(0, 15)));
            end else begin
                idle(1);
            end
        end
        idle(2);

        // reset asserted while a read is in flight
        acc(1'b0, BASE + 32'h40, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("inflight_ready", {63'd0, o_ready}, 64'd0);
        check("inflight_data", {32'd0, o_data}, 64'd0);
        check("inflight_int", {63'd0, o_int}, 64'd0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        acc(1'b0, BASE + 32'h08, 32'h0, 4'hF);
        acc(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
